// File: rtl/param_sram.sv
// Single-clock word SRAM with a sequential boot-load port, a registered read
// port and a byte-enabled write port. Reads and writes are only served in RUN.
module param_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 32,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int NB     = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_start,
  input  logic              init_valid,
  input  logic [DATA_W-1:0] init_data,
  input  logic              init_last,
  output logic              init_ready,
  output logic              init_done,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [NB-1:0]     wr_be,
  input  logic [DATA_W-1:0] wr_data,
  output logic              req_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  logic [DATA_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              req_err_q, req_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [NB-1:0]     mem_be;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    req_err_d  = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = cnt_q;
    mem_wdata  = init_data;
    mem_be     = '1;

    case (state_q)
      IDLE: begin
        if (init_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
      end
      LOAD: begin
        // The counter stops at the last word instead of wrapping.
        if (init_valid) begin
          mem_we = 1'b1;
          if (init_last || cnt_q == LAST_ADDR) state_d = RUN;
          else                                 cnt_d   = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (init_start) begin
          state_d = LOAD;
          cnt_d   = '0;
        end
        // Read samples the array before this edge's write: old data on collision.
        if (rd_en) begin
          rd_data_d  = mem[rd_addr];
          rd_valid_d = 1'b1;
        end
        if (wr_en) begin
          mem_we    = 1'b1;
          mem_addr  = wr_addr;
          mem_wdata = wr_data;
          mem_be    = wr_be;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != RUN && (rd_en || wr_en)) req_err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      req_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      req_err_q  <= req_err_d;
    end
  end

  // Storage is deliberately not reset so contents survive a reset mid-load.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < NB; i++) begin
        if (mem_be[i]) mem[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];
      end
    end
  end

  assign init_ready = (state_q == LOAD);
  assign init_done  = (state_q == RUN);
  assign rd_data    = rd_data_q;
  assign rd_valid   = rd_valid_q;
  assign req_err    = req_err_q;

endmodule

// File: tb/tb_param_sram.sv
// Directed bench for param_sram: boot load, reads, byte writes, collisions,
// requests outside RUN and reset in the middle of a load.
module tb_param_sram;

  logic        clk = 1'b0;
  logic        reset;
  logic        init_start, init_valid, init_last;
  logic [31:0] init_data;
  logic        init_ready, init_done;
  logic        rd_en, rd_valid;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        req_err;

  int errors = 0;
  int checks = 0;

  param_sram #(.DATA_W(32), .DEPTH(32)) dut (
    .clk(clk), .reset(reset),
    .init_start(init_start), .init_valid(init_valid), .init_data(init_data),
    .init_last(init_last), .init_ready(init_ready), .init_done(init_done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_be(wr_be), .wr_data(wr_data),
    .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    tick();
    rd_en = 1'b0;
    chk({tag, "_valid"}, {31'b0, rd_valid}, 32'd1);
    chk({tag, "_data"}, rd_data, exp);
  endtask

  task automatic write_word(input logic [4:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic start_load();
    init_start = 1'b1;
    tick();
    init_start = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    init_start = 0; init_valid = 0; init_last = 0; init_data = '0;
    rd_en = 0; rd_addr = '0; wr_en = 0; wr_addr = '0; wr_be = '0; wr_data = '0;
    tick(); tick();
    chk("rst_ready", {31'b0, init_ready}, 32'd0);
    chk("rst_done", {31'b0, init_done}, 32'd0);
    chk("rst_rdvalid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rddata", rd_data, 32'd0);
    chk("rst_reqerr", {31'b0, req_err}, 32'd0);
    reset = 1'b0;
    tick();

    // Full 32-word load ends at the DEPTH-1 word without init_last.
    start_load();
    chk("t1_ready", {31'b0, init_ready}, 32'd1);
    init_valid = 1'b1;
    for (int i = 0; i < 32; i++) begin
      init_data = 32'h1000 + i;
      tick();
      if (i == 30) chk("t1_done_early", {31'b0, init_done}, 32'd0);
    end
    init_valid = 1'b0;
    chk("t1_done", {31'b0, init_done}, 32'd1);
    chk("t1_ready_off", {31'b0, init_ready}, 32'd0);
    read_chk("t1_rd5", 5'd5, 32'h1005);
    tick();
    chk("t1_valid_pulse", {31'b0, rd_valid}, 32'd0);
    chk("t1_hold", rd_data, 32'h1005);

    // Byte-enabled write onto a known word; zero enables are a no-op.
    write_word(5'd7, 4'hF, 32'hAABBCCDD);
    write_word(5'd7, 4'b0101, 32'h11223344);
    read_chk("t3_be", 5'd7, 32'hAA22CC44);
    write_word(5'd7, 4'h0, 32'h0);
    read_chk("t3_be0", 5'd7, 32'hAA22CC44);

    // Same-cycle read and write returns the old word.
    write_word(5'd2, 4'hF, 32'h0);
    rd_en = 1'b1; rd_addr = 5'd2;
    wr_en = 1'b1; wr_addr = 5'd2; wr_be = 4'hF; wr_data = 32'hFFFFFFFF;
    tick();
    rd_en = 1'b0; wr_en = 1'b0;
    chk("t4_old", rd_data, 32'h0);
    read_chk("t4_new", 5'd2, 32'hFFFFFFFF);

    // Reload from RUN with init_last on the 4th word.
    start_load();
    chk("t2_reload_ready", {31'b0, init_ready}, 32'd1);
    init_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      init_data = 32'hB0 + i;
      init_last = (i == 3);
      tick();
      if (i == 2) chk("t2_done_early", {31'b0, init_done}, 32'd0);
    end
    init_valid = 1'b0; init_last = 1'b0;
    chk("t2_done", {31'b0, init_done}, 32'd1);
    read_chk("t2_rd3", 5'd3, 32'hB3);
    read_chk("t2_rd2", 5'd2, 32'hB2);
    read_chk("t2_rd4", 5'd4, 32'h1004);

    // Requests during LOAD, a stray init_start, and a toggling valid.
    start_load();
    rd_en = 1'b1; rd_addr = 5'd0;
    tick();
    rd_en = 1'b0;
    chk("t5_reqerr", {31'b0, req_err}, 32'd1);
    chk("t5_rdvalid", {31'b0, rd_valid}, 32'd0);
    chk("t5_rdhold", rd_data, 32'h1004);
    tick();
    chk("t5_reqerr_pulse", {31'b0, req_err}, 32'd0);
    wr_en = 1'b1; wr_addr = 5'd4; wr_be = 4'hF; wr_data = 32'hBAD0BAD0;
    tick();
    wr_en = 1'b0;
    chk("t5_wr_reqerr", {31'b0, req_err}, 32'd1);
    for (int i = 0; i < 8; i++) begin
      init_valid = (i % 2 == 0);
      init_data  = init_valid ? 32'hC0 + i / 2 : 32'hDEAD;
      init_last  = (i == 6);
      init_start = (i == 3);
      tick();
    end
    init_valid = 1'b0; init_last = 1'b0; init_start = 1'b0;
    chk("t5_done", {31'b0, init_done}, 32'd1);
    read_chk("t5_rd0", 5'd0, 32'hC0);
    read_chk("t5_rd1", 5'd1, 32'hC1);
    read_chk("t5_rd3", 5'd3, 32'hC3);
    read_chk("t5_rd4", 5'd4, 32'h1004);

    // Reset after 10 loaded words, then a 2-word reload.
    start_load();
    init_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      init_data = 32'hE0 + i;
      tick();
    end
    init_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("t6_ready", {31'b0, init_ready}, 32'd0);
    chk("t6_done", {31'b0, init_done}, 32'd0);
    chk("t6_rddata", rd_data, 32'd0);
    chk("t6_rdvalid", {31'b0, rd_valid}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    start_load();
    init_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      init_data = 32'hF0 + i;
      init_last = (i == 1);
      tick();
    end
    init_valid = 1'b0; init_last = 1'b0;
    chk("t6_done2", {31'b0, init_done}, 32'd1);
    read_chk("t6_rd0", 5'd0, 32'hF0);
    read_chk("t6_rd1", 5'd1, 32'hF1);
    read_chk("t6_rd2", 5'd2, 32'hE2);
    read_chk("t6_rd9", 5'd9, 32'hE9);
    read_chk("t6_rd10", 5'd10, 32'h100A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
